// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count for one cycle.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s) from a valid/ready stream.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  uart_tx_state_t       state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 tick;
  logic                 accept;
  logic                 last_stop;
  logic                 par_bit;

  // Ready opens in the final stop cycle so a waiting byte follows with no idle gap.
  assign last_stop = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
  assign tx_ready  = !rst && ((state_q == ST_IDLE) || last_stop);
  assign accept    = tx_valid && tx_ready;
  assign par_bit   = (PARITY == PARITY_ODD) ? ~par_q : par_q;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept || (state_q == ST_IDLE)),
    .tick_o(tick)
  );

  // Line and busy are registered from the current state, so both lag the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_q != ST_IDLE);
      case (state_q)
        ST_START:  tx_q <= 1'b0;
        ST_DATA:   tx_q <= shift_q[0];
        ST_PARITY: tx_q <= par_bit;
        default:   tx_q <= 1'b1;
      endcase

      if (accept) begin
        state_q   <= ST_START;
        shift_q   <= tx_data;
        bit_cnt_q <= '0;
        par_q     <= 1'b0;
      end else if (tick) begin
        case (state_q)
          ST_START: state_q <= ST_DATA;
          ST_DATA: begin
            shift_q <= shift_q >> 1;
            par_q   <= par_q ^ shift_q[0];
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          ST_PARITY: state_q <= ST_STOP;
          ST_STOP: begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: several configurations run side by side against a frame-level line model.
module tb_uart_tx;

  localparam int NCFG = 7;

  function automatic int cfg_clk(input int i);
    case (i)
      4:       return 1_000_000;
      5:       return 10_000_000;
      6:       return 2;
      default: return 100_000_000;
    endcase
  endfunction

  function automatic int cfg_baud(input int i);
    case (i)
      4:       return 250_000;
      5:       return 3_333_333;
      6:       return 1;
      default: return 115_200;
    endcase
  endfunction

  function automatic int cfg_db(input int i);
    case (i)
      3:       return 7;
      5:       return 5;
      6:       return 6;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_par(input int i);
    case (i)
      1, 4:    return 1;
      2, 5:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_stop(input int i);
    case (i)
      3, 5:    return 2;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g
    localparam int CPB = cfg_clk(gi) / cfg_baud(gi);
    localparam int DB  = cfg_db(gi);
    localparam int PAR = cfg_par(gi);
    localparam int SB  = cfg_stop(gi);
    localparam int FL  = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CPB;

    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_ready;
    logic          tx;
    logic          tx_busy;

    uart_tx #(
      .CLK_FREQ (cfg_clk(gi)),
      .BAUD_RATE(cfg_baud(gi)),
      .DATA_BITS(DB),
      .PARITY   (PAR),
      .STOP_BITS(SB)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx      (tx),
      .tx_busy (tx_busy)
    );

    // Line model: the latest accepted byte defines the frame; slot j covers CPB cycles.
    bit            has = 1'b0;
    int            acc = 0;
    int            busy_from = 0;
    int            busy_until = 0;
    logic [DB-1:0] mdat = '0;

    function automatic logic slot(input int j);
      if (j == 0) return 1'b0;
      if (j <= DB) return mdat[j-1];
      if (PAR != 0 && j == DB + 1) return (PAR == 2) ? ~(^mdat) : ^mdat;
      return 1'b1;
    endfunction

    always @(negedge clk) begin : cmp
      logic [2:0] e;
      if (rst) begin
        has = 1'b0;
        e   = 3'b100;
      end else begin
        e[0] = !has || (cyc >= acc + FL);
        e[1] = has && (cyc >= busy_from) && (cyc <= busy_until);
        e[2] = (has && cyc >= acc + 2 && cyc <= acc + FL + 1) ? slot((cyc - acc - 2) / CPB) : 1'b1;
      end
      chk($sformatf("cfg%0d {tx,busy,ready}", gi), int'({tx, tx_busy, tx_ready}), int'(e));
      if (!rst && tx_valid && e[0]) begin
        if (!(has && busy_until >= cyc + 1)) busy_from = cyc + 2;
        busy_until = cyc + FL + 1;
        acc        = cyc;
        mdat       = tx_data;
        has        = 1'b1;
      end
    end

    int run = 0;
    int last_run = 0;
    int runs = 0;
    always @(negedge clk) begin
      if (tx_busy) begin
        run++;
      end else if (run != 0) begin
        last_run = run;
        runs++;
        run = 0;
      end
    end

    task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
      bit got = 1'b0;
      tx_data  = d[DB-1:0];
      tx_valid = 1'b1;
      for (int k = 0; k < FL + 10; k++) begin
        @(negedge clk);
        if (tx_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk($sformatf("cfg%0d accept wait", gi), 0, 1);
      step(1);
      if (!hold) tx_valid = 1'b0;
    endtask

    task automatic pin_bits(input int nslots, input logic [15:0] pat, input int skip);
      step(1 + CPB / 2 - skip);
      for (int k = 0; k < nslots; k++) begin
        chk($sformatf("cfg%0d slot%0d", gi, k), int'(tx), int'(pat[k]));
        if (k < nslots - 1) step(CPB);
      end
    endtask

    task automatic wait_idle();
      bit idle = 1'b0;
      for (int k = 0; k < 2 * FL + 10; k++) begin
        @(negedge clk);
        if (!tx_busy) begin
          idle = 1'b1;
          break;
        end
      end
      if (!idle) chk($sformatf("cfg%0d idle wait", gi), 0, 1);
      step(1);
    endtask

    if (gi == 0) begin : directed_main
      initial begin
        step(3);
        chk("cfg0 reset outs", int'({tx, tx_busy, tx_ready}), 3'b100);
        rst = 1'b0;
        #1;
        chk("cfg0 ready after reset", int'(tx_ready), 1);

        send(8'h55, 1'b0);
        pin_bits(10, 16'h02AA, 0);
        wait_idle();
        chk("cfg0 busy len 0x55", last_run, 8680);
        chk("cfg0 ready after 0x55", int'(tx_ready), 1);

        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        tx_data = 8'hFF;
        step(300);
        tx_valid = 1'b0;
        pin_bits(10, 16'h0278, 300);
        wait_idle();
        chk("cfg0 busy len back-to-back", last_run, 17360);

        send(8'h00, 1'b0);
        step(3000);
        chk("cfg0 tx low mid-frame", int'(tx), 0);
        rst = 1'b1;
        #1;
        chk("cfg0 async reset outs", int'({tx, tx_busy, tx_ready}), 3'b100);
        step(2);
        rst = 1'b0;
        #1;
        chk("cfg0 ready after mid reset", int'(tx_ready), 1);
        send(8'h81, 1'b0);
        pin_bits(10, 16'h0302, 0);
        wait_idle();
        chk("cfg0 busy len 0x81", last_run, 8680);
        done_cnt++;
      end
    end else if (gi <= 3) begin : directed_cfg
      initial begin
        step(2);
        rst = 1'b0;
        #1;
        send((gi == 3) ? 8'h7F : 8'h01, 1'b0);
        pin_bits((gi == 3) ? 10 : 11, (gi == 1) ? 16'h0602 : (gi == 2) ? 16'h0402 : 16'h03FE, 0);
        wait_idle();
        chk($sformatf("cfg%0d busy len", gi), last_run, (gi == 3) ? 8680 : 9548);
        done_cnt++;
      end
    end else begin : random_cfg
      initial begin
        step(2);
        rst = 1'b0;
        for (int c = 0; c < 20000; c++) begin
          tx_valid = ($urandom_range(3) != 0);
          tx_data  = DB'($urandom);
          rst      = ($urandom_range(2999) == 0);
          step(1);
        end
        tx_valid = 1'b0;
        rst      = 1'b0;
        wait_idle();
        chk($sformatf("cfg%0d enough frames", gi), int'(runs >= 50), 1);
        done_cnt++;
      end
    end
  end

  initial begin
    bit ok = 1'b0;
    for (int k = 0; k < 90000; k++) begin
      @(posedge clk);
      if (done_cnt == NCFG) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("run completion", done_cnt, NCFG);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
